irq_front_end: RTL and testbench

- Sits upstream of the interrupt handler and core PC-select logic.
- Synchronises the two asynchronous external interrupt pins (high- and low-priority) to clk and detects rising edges.
- Latches each edge as a pending request, applies per-source enables and fixed priority, and presents one request at a time to the core with a vector.
- Tracks in-service state until the ISR signals completion, so requests never overlap and edges are never lost silently.

---
 rtl/irq_front_end.sv | 209 ++++++++++++++++++++
 tb/tb_irq_front_end.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_front_end.sv
// irq_front_end
// Interrupt front end: synchronises the high- and low-priority external
// interrupt pins, detects rising edges and latches them as pending requests.
// It then presents one enabled request at a time to the core, with fixed
// priority and an ISR vector, and tracks the in-service state until the ISR
// returns.

// Per-pin synchroniser chain followed by a history flop for rising-edge detect.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Shift the raw pin through the synchroniser and remember the previous output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_hist <= w_sync_out;
        end
    end

    // A pin already high when reset releases still yields one pulse,
    // because the chain and the history flop both restart from zero.
    assign o_rise = w_sync_out & ~r_hist;

endmodule

// Top level: pending latches, lost flags and the request/service FSM.
module irq_front_end #(
    parameter logic [31:0] VEC_HIGH    = 32'h0000_0000,
    parameter logic [31:0] VEC_LOW     = 32'h0000_0015,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq_high_pin,
    input  logic        irq_low_pin,
    input  logic [1:0]  irq_en,
    input  logic        int_ack,
    input  logic        isr_done,
    output logic        int_req,
    output logic [31:0] int_vector,
    output logic        int_id,
    output logic        in_service,
    output logic [1:0]  pending,
    output logic [1:0]  lost
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_int_req;
    logic [31:0] r_int_vector;
    logic        r_int_id;
    logic        r_in_service;
    logic [1:0]  r_pending;
    logic [1:0]  r_lost;

    logic        w_rise_high;
    logic        w_rise_low;
    logic [1:0]  w_rise;
    logic [1:0]  w_clr;
    logic [1:0]  w_eligible;

    // Fixed priority: the high source wins whenever it is eligible.
    function automatic logic pick_id(input logic [1:0] elig);
        logic id;
        if (elig[1]) begin
            id = 1'b1;
        end else begin
            id = 1'b0;
        end
        return id;
    endfunction

    // Map a source id onto its ISR start address.
    function automatic logic [31:0] pick_vector(input logic id);
        logic [31:0] vec;
        if (id) begin
            vec = VEC_HIGH;
        end else begin
            vec = VEC_LOW;
        end
        return vec;
    endfunction

    irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_high (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (irq_high_pin),
        .o_rise (w_rise_high)
    );

    irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_low (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (irq_low_pin),
        .o_rise (w_rise_low)
    );

    assign w_rise     = {w_rise_high, w_rise_low};
    assign w_eligible = r_pending & irq_en;

    // Acknowledge clears only the pending bit of the source being presented.
    always_comb begin
        w_clr = 2'b00;
        if ((r_state == ST_REQ) && int_ack) begin
            if (r_int_id) begin
                w_clr = 2'b10;
            end else begin
                w_clr = 2'b01;
            end
        end else begin
            w_clr = 2'b00;
        end
    end

    // Pending latches (a new edge beats a same-cycle clear) and sticky lost flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 2'b00;
            r_lost    <= 2'b00;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_lost    <= r_lost | (w_rise & r_pending & ~w_clr);
        end
    end

    // Request/service sequencer; every core-facing output is a register here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_int_req    <= 1'b0;
            r_int_vector <= 32'h0000_0000;
            r_int_id     <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_eligible != 2'b00) begin
                        r_int_id     <= pick_id(w_eligible);
                        r_int_vector <= pick_vector(pick_id(w_eligible));
                        r_int_req    <= 1'b1;
                        r_state      <= ST_REQ;
                    end else begin
                        r_int_req    <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // The request is frozen: enable changes and newer edges
                    // only affect what is selected after this one is served.
                    if (int_ack) begin
                        r_int_req    <= 1'b0;
                        r_in_service <= 1'b1;
                        r_state      <= ST_SERVICE;
                    end else begin
                        r_int_req    <= 1'b1;
                        r_state      <= ST_REQ;
                    end
                end
                ST_SERVICE: begin
                    // No nesting: new edges only land in the pending latches.
                    if (isr_done) begin
                        r_in_service <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_in_service <= 1'b1;
                        r_state      <= ST_SERVICE;
                    end
                end
                default: begin
                    r_int_req    <= 1'b0;
                    r_in_service <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign int_req    = r_int_req;
    assign int_vector = r_int_vector;
    assign int_id     = r_int_id;
    assign in_service = r_in_service;
    assign pending    = r_pending;
    assign lost       = r_lost;

endmodule

// File: tb/tb_irq_front_end.sv
// Directed testbench for irq_front_end: each scenario task drives its own
// stimulus and compares outputs against hand-computed values.
`timescale 1ns/1ps
module tb_irq_front_end;

    logic        clk;
    logic        rst;
    logic        irq_high_pin;
    logic        irq_low_pin;
    logic [1:0]  irq_en;
    logic        int_ack;
    logic        isr_done;
    logic        int_req;
    logic [31:0] int_vector;
    logic        int_id;
    logic        in_service;
    logic [1:0]  pending;
    logic [1:0]  lost;

    int vectors;
    int miscompares;

    irq_front_end #(
        .VEC_HIGH    (32'h0000_0000),
        .VEC_LOW     (32'h0000_0015),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_high_pin (irq_high_pin),
        .irq_low_pin  (irq_low_pin),
        .irq_en       (irq_en),
        .int_ack      (int_ack),
        .isr_done     (isr_done),
        .int_req      (int_req),
        .int_vector   (int_vector),
        .int_id       (int_id),
        .in_service   (in_service),
        .pending      (pending),
        .lost         (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
    endtask

    task automatic pulse_done();
        isr_done = 1'b1;
        tick(1);
        isr_done = 1'b0;
    endtask

    task automatic test_initial_reset();
        rst = 1'b1;
        tick(2);
        vectors++;
        if ({int_req, in_service, pending, lost} !== 6'b0) begin
            miscompares++;
            $display("FAIL init_reset: got req/svc/pend/lost=%b want 000000", {int_req, in_service, pending, lost});
        end
        vectors++;
        if (int_vector !== 32'h0) begin
            miscompares++;
            $display("FAIL init_vector: got %h want 00000000", int_vector);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_single_low();
        irq_en = 2'b11;
        irq_low_pin = 1'b1;
        tick(3);
        vectors++;
        if (pending !== 2'b01 || int_req !== 1'b0) begin
            miscompares++;
            $display("FAIL low_pending_e3: got pend=%b req=%b want pend=01 req=0", pending, int_req);
        end
        tick(1);
        vectors++;
        if (int_req !== 1'b1 || int_id !== 1'b0 || int_vector !== 32'h15) begin
            miscompares++;
            $display("FAIL low_req_e4: got req=%b id=%b vec=%h want 1 0 00000015", int_req, int_id, int_vector);
        end
        pulse_ack();
        vectors++;
        if (pending !== 2'b00 || in_service !== 1'b1 || int_req !== 1'b0) begin
            miscompares++;
            $display("FAIL low_ack: got pend=%b svc=%b req=%b want 00 1 0", pending, in_service, int_req);
        end
        pulse_done();
        vectors++;
        if (in_service !== 1'b0) begin
            miscompares++;
            $display("FAIL low_done: got svc=%b want 0", in_service);
        end
        irq_low_pin = 1'b0;
        tick(4);
    endtask

    task automatic test_priority();
        irq_high_pin = 1'b1;
        irq_low_pin  = 1'b1;
        tick(3);
        vectors++;
        if (pending !== 2'b11) begin
            miscompares++;
            $display("FAIL prio_pending: got %b want 11", pending);
        end
        tick(1);
        vectors++;
        if (int_req !== 1'b1 || int_id !== 1'b1 || int_vector !== 32'h0) begin
            miscompares++;
            $display("FAIL prio_first: got req=%b id=%b vec=%h want 1 1 00000000", int_req, int_id, int_vector);
        end
        pulse_ack();
        vectors++;
        if (pending !== 2'b01 || in_service !== 1'b1 || int_id !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_ack_high: got pend=%b svc=%b id=%b want 01 1 1", pending, in_service, int_id);
        end
        pulse_done();
        vectors++;
        if (int_req !== 1'b0 || in_service !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_gap: got req=%b svc=%b want 0 0", int_req, in_service);
        end
        tick(1);
        vectors++;
        if (int_req !== 1'b1 || int_id !== 1'b0 || int_vector !== 32'h15) begin
            miscompares++;
            $display("FAIL prio_second: got req=%b id=%b vec=%h want 1 0 00000015", int_req, int_id, int_vector);
        end
        pulse_ack();
        pulse_done();
        irq_high_pin = 1'b0;
        irq_low_pin  = 1'b0;
        tick(4);
    endtask

    task automatic test_masking();
        irq_en = 2'b01;
        irq_high_pin = 1'b1;
        tick(3);
        vectors++;
        if (pending !== 2'b10) begin
            miscompares++;
            $display("FAIL mask_pending: got %b want 10", pending);
        end
        tick(3);
        vectors++;
        if (int_req !== 1'b0) begin
            miscompares++;
            $display("FAIL mask_blocked: got req=%b want 0", int_req);
        end
        irq_en = 2'b11;
        tick(1);
        vectors++;
        if (int_req !== 1'b1 || int_id !== 1'b1 || int_vector !== 32'h0) begin
            miscompares++;
            $display("FAIL mask_unmask: got req=%b id=%b vec=%h want 1 1 00000000", int_req, int_id, int_vector);
        end
        pulse_ack();
        pulse_done();
        irq_high_pin = 1'b0;
        tick(4);
    endtask

    task automatic test_coalesce_lost();
        irq_low_pin = 1'b1;
        tick(4);
        pulse_ack();
        irq_low_pin = 1'b0;
        tick(3);
        for (int p = 0; p < 2; p++) begin
            irq_low_pin = 1'b1;
            tick(2);
            irq_low_pin = 1'b0;
            tick(3);
        end
        vectors++;
        if (pending !== 2'b01 || lost !== 2'b01 || in_service !== 1'b1 || int_req !== 1'b0) begin
            miscompares++;
            $display("FAIL coalesce: got pend=%b lost=%b svc=%b req=%b want 01 01 1 0", pending, lost, in_service, int_req);
        end
        pulse_done();
        tick(1);
        vectors++;
        if (int_req !== 1'b1 || int_id !== 1'b0) begin
            miscompares++;
            $display("FAIL coalesce_req: got req=%b id=%b want 1 0", int_req, int_id);
        end
        pulse_ack();
        pulse_done();
        tick(3);
        vectors++;
        if (int_req !== 1'b0 || pending !== 2'b00 || lost !== 2'b01) begin
            miscompares++;
            $display("FAIL coalesce_once: got req=%b pend=%b lost=%b want 0 00 01", int_req, pending, lost);
        end
    endtask

    task automatic test_reset();
        irq_high_pin = 1'b1;
        irq_low_pin  = 1'b1;
        tick(4);
        vectors++;
        if (int_req !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_setup: got req=%b want 1", int_req);
        end
        rst = 1'b1;
        tick(1);
        vectors++;
        if ({int_req, int_id, in_service, pending, lost} !== 7'b0 || int_vector !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid_req: got req/id/svc/pend/lost=%b vec=%h want 0000000 00000000", {int_req, int_id, in_service, pending, lost}, int_vector);
        end
        irq_low_pin = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(3);
        vectors++;
        if (pending !== 2'b10 || lost !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_release_high: got pend=%b lost=%b want 10 00", pending, lost);
        end
        tick(1);
        vectors++;
        if (int_req !== 1'b1 || int_id !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_release_req: got req=%b id=%b want 1 1", int_req, int_id);
        end
        pulse_ack();
        pulse_done();
        irq_high_pin = 1'b0;
        tick(4);
    endtask

    task automatic test_boundary();
        irq_low_pin = 1'b1;
        tick(4);
        irq_low_pin = 1'b0;
        tick(4);
        vectors++;
        if (int_req !== 1'b1 || pending !== 2'b01) begin
            miscompares++;
            $display("FAIL bnd_setup: got req=%b pend=%b want 1 01", int_req, pending);
        end
        irq_low_pin = 1'b1;
        tick(2);
        pulse_ack();
        vectors++;
        if (pending !== 2'b01 || lost !== 2'b00 || in_service !== 1'b1) begin
            miscompares++;
            $display("FAIL bnd_set_wins: got pend=%b lost=%b svc=%b want 01 00 1", pending, lost, in_service);
        end
        pulse_done();
        tick(1);
        vectors++;
        if (int_req !== 1'b1 || int_id !== 1'b0 || int_vector !== 32'h15) begin
            miscompares++;
            $display("FAIL bnd_second_req: got req=%b id=%b vec=%h want 1 0 00000015", int_req, int_id, int_vector);
        end
        pulse_ack();
        pulse_done();
        irq_low_pin = 1'b0;
        tick(4);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        irq_high_pin = 1'b0;
        irq_low_pin  = 1'b0;
        irq_en       = 2'b11;
        int_ack      = 1'b0;
        isr_done     = 1'b0;
        #2;
        test_initial_reset();
        test_single_low();
        test_priority();
        test_masking();
        test_coalesce_lost();
        test_reset();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000ns");
        $fatal(1);
    end

endmodule
